// File: rtl/sha3_state_serializer_if.sv
// Handshake bundle for the Keccak state serializer: a state capture side (i_*) and a
// beat stream side (o_*). The master drives the state and accepts beats; the slave serializes.
interface sha3_state_serializer_if #(
  parameter int unsigned OUT_WIDTH   = 48,
  parameter int unsigned SPARE_WIDTH = 16
);
  localparam int unsigned Beats = (1600 + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  logic                   i_valid;
  logic                   i_ready;
  logic [63:0]            istate [25];
  logic [SPARE_WIDTH-1:0] ispare;
  logic                   o_valid;
  logic                   o_ready;
  logic [OUT_WIDTH-1:0]   ovector;
  logic [BeatW-1:0]       o_beat;
  logic                   o_last;

  modport master (
    output i_valid, istate, ispare, o_ready,
    input  i_ready, o_valid, ovector, o_beat, o_last
  );

  modport slave (
    input  i_valid, istate, ispare, o_ready,
    output i_ready, o_valid, ovector, o_beat, o_last
  );
endinterface

// File: rtl/sha3_state_serializer.sv
// Streams a captured 1600-bit Keccak state plus a side-band word as OUT_WIDTH-bit beats,
// MSB first, with valid/ready on both sides and zero-bubble back-to-back captures.
module sha3_state_serializer #(
  parameter int unsigned OUT_WIDTH   = 48,
  parameter int unsigned SPARE_WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  sha3_state_serializer_if.slave bus
);
  localparam int unsigned Beats  = (1600 + OUT_WIDTH - 1) / OUT_WIDTH;
  localparam int unsigned TotalW = Beats * OUT_WIDTH;
  localparam int unsigned Pad    = TotalW - 1600;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;

  if (SPARE_WIDTH < 1 || SPARE_WIDTH > Pad) begin : g_bad_spare
    $error("SPARE_WIDTH must lie in 1..PAD for the chosen OUT_WIDTH");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [TotalW-1:0]   sreg_q, sreg_d;
  logic [TotalW-1:0]   packed_w;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic                last_w, accept_w, capture_w;

  // Lane 0 lands in the top bits; the side-band word sits at the very bottom.
  always_comb begin
    packed_w = '0;
    for (int unsigned i = 0; i < 25; i++) begin
      packed_w[TotalW-1-64*i -: 64] = bus.istate[i];
    end
    packed_w[SPARE_WIDTH-1:0] = bus.ispare;
  end

  assign bus.o_valid = (state_q == StSend);
  assign last_w      = bus.o_valid && (beat_q == BeatW'(Beats - 1));
  assign bus.o_last  = last_w;
  assign bus.o_beat  = beat_q;
  assign bus.ovector = sreg_q[TotalW-1 -: OUT_WIDTH];
  assign accept_w    = bus.o_valid & bus.o_ready;
  assign bus.i_ready = (state_q == StIdle) | (accept_w & last_w);
  assign capture_w   = bus.i_valid & bus.i_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    beat_d  = beat_q;
    unique case (state_q)
      StIdle: begin
        if (capture_w) begin
          state_d = StSend;
          sreg_d  = packed_w;
          beat_d  = '0;
        end
      end
      StSend: begin
        if (accept_w) begin
          if (last_w) begin
            beat_d = '0;
            if (capture_w) begin
              sreg_d = packed_w;
            end else begin
              state_d = StIdle;
            end
          end else begin
            sreg_d = sreg_q << OUT_WIDTH;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_sha3_state_serializer.sv
// Scoreboard bench for the state serializer: captures push bit-level reference beats,
// an output monitor pops and compares on every accepted beat.
module tb_sha3_state_serializer;
  localparam int unsigned OW    = 48;
  localparam int unsigned SW    = 16;
  localparam int unsigned Beats = (1600 + OW - 1) / OW;
  localparam int unsigned Pad   = Beats * OW - 1600;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sha3_state_serializer_if #(.OUT_WIDTH(OW), .SPARE_WIDTH(SW)) bus ();

  sha3_state_serializer #(.OUT_WIDTH(OW), .SPARE_WIDTH(SW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [OW-1:0]    data;
    logic [BeatW-1:0] idx;
    logic             last;
  } beat_t;

  beat_t           sb[$];
  logic [OW-1:0]   log_data[$];
  int unsigned     log_cyc[$];
  logic [OW-1:0]   ref1[$];
  logic [63:0]     lanes[25];
  logic [SW-1:0]   spare;
  int unsigned     vectors = 0;
  int unsigned     errors  = 0;
  int unsigned     cycle   = 0;
  bit              ready_rand = 0;
  bit              scramble   = 0;
  bit              prev_stall = 0;
  logic [OW-1:0]   prev_vec;
  logic [BeatW-1:0] prev_beat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: flatten the state into a bit list, then cut it into OW-bit beats.
  task automatic model_push();
    bit    bits[$];
    beat_t e;
    for (int i = 0; i < 25; i++)
      for (int b = 63; b >= 0; b--) bits.push_back(bus.istate[i][b]);
    for (int i = 0; i < int'(Pad - SW); i++) bits.push_back(1'b0);
    for (int b = int'(SW) - 1; b >= 0; b--) bits.push_back(bus.ispare[b]);
    for (int k = 0; k < int'(Beats); k++) begin
      for (int j = 0; j < int'(OW); j++) e.data[OW-1-j] = bits[k*OW+j];
      e.idx  = BeatW'(k);
      e.last = (k == int'(Beats) - 1);
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      cycle++;
      check("o_valid_vs_pending", bus.o_valid, sb.size() != 0);
      check("i_ready_rule", bus.i_ready, !bus.o_valid || (bus.o_ready && bus.o_last));
      if (prev_stall) begin
        check("hold_ovector", bus.ovector, prev_vec);
        check("hold_o_beat", bus.o_beat, prev_beat);
      end
      prev_stall = bus.o_valid && !bus.o_ready;
      prev_vec   = bus.ovector;
      prev_beat  = bus.o_beat;
      if (bus.o_valid && bus.o_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_beat: got beat %0d, expected none", bus.o_beat);
        end else begin
          e = sb.pop_front();
          check("beat_data", bus.ovector, e.data);
          check("beat_index", bus.o_beat, e.idx);
          check("beat_last", bus.o_last, e.last);
          log_data.push_back(bus.ovector);
          log_cyc.push_back(cycle);
        end
      end
      if (bus.i_valid && bus.i_ready) model_push();
    end
  end

  always @(posedge clk) begin
    #1;
    bus.o_ready = ready_rand ? 1'($urandom % 2) : 1'b1;
    if (scramble)
      for (int i = 0; i < 25; i++) bus.istate[i] = {$urandom, $urandom};
  end

  task automatic load_random();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
    spare = SW'($urandom);
  endtask

  task automatic apply_lanes();
    for (int i = 0; i < 25; i++) bus.istate[i] = lanes[i];
    bus.ispare = spare;
  endtask

  task automatic wait_hs();
    bit ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.i_valid && bus.i_ready;
    end
    if (!ok) begin
      vectors++;
      errors++;
      $display("FAIL capture_timeout: got no handshake, expected one within 1000 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_capture();
    apply_lanes();
    bus.i_valid = 1'b1;
    wait_hs();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk);
      #2;
      done = (sb.size() == 0) && !bus.o_valid;
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_cyc.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.i_valid = 1'b0;
    bus.ispare  = '0;
    for (int i = 0; i < 25; i++) bus.istate[i] = '0;
    bus.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", bus.o_valid, 1'b0);
    check("reset_i_ready", bus.i_ready, 1'b1);
    check("reset_o_beat", bus.o_beat, '0);
    check("reset_o_last", bus.o_last, 1'b0);
    check("reset_ovector", bus.ovector, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Known pattern, full-rate downstream.
    for (int n = 0; n < 25; n++) lanes[n] = {8{8'(n)}};
    spare = 16'hBEEF;
    clear_log();
    drive_capture();
    drain();
    check("s1_beat_count", log_data.size(), Beats);
    if (log_data.size() == Beats) begin
      check("s1_beat0", log_data[0], 48'h0);
      check("s1_beat1", log_data[1], {16'h0000, 32'h0101_0101});
      check("s1_beat33", log_data[33], {16'h1818, 16'h0000, 16'hBEEF});
    end
    ref1 = log_data;

    // Same pattern under random backpressure.
    ready_rand = 1;
    clear_log();
    drive_capture();
    drain();
    ready_rand = 0;
    check("s2_beat_count", log_data.size(), Beats);
    for (int i = 0; i < int'(Beats) && i < log_data.size(); i++)
      check("s2_vs_s1", log_data[i], ref1[i]);

    // Back-to-back captures with i_valid held high.
    @(posedge clk);
    #1;
    clear_log();
    load_random();
    apply_lanes();
    bus.i_valid = 1'b1;
    wait_hs();
    load_random();
    apply_lanes();
    wait_hs();
    bus.i_valid = 1'b0;
    drain();
    check("s3_beat_count", log_data.size(), 2 * Beats);
    if (log_data.size() == 2 * Beats)
      check("s3_cycles", log_cyc[2*Beats-1] - log_cyc[0], 2 * Beats - 1);

    // Inputs churn every cycle while a snapshot streams out.
    clear_log();
    load_random();
    drive_capture();
    scramble = 1;
    bus.i_valid = 1'b1;
    wait_hs();
    scramble = 0;
    bus.i_valid = 1'b0;
    drain();
    check("s4_beat_count", log_data.size(), 2 * Beats);

    // Asynchronous reset in the middle of a stream.
    load_random();
    drive_capture();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = bus.o_valid && (bus.o_beat == BeatW'(10));
    end
    check("s5_reached_beat10", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_rst_o_valid", bus.o_valid, 1'b0);
    check("s5_rst_o_beat", bus.o_beat, '0);
    check("s5_rst_ovector", bus.ovector, '0);
    check("s5_rst_o_last", bus.o_last, 1'b0);
    sb.delete();
    prev_stall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    load_random();
    drive_capture();
    drain();
    check("s5_post_reset_count", log_data.size(), Beats);

    // Random states under random backpressure.
    ready_rand = 1;
    for (int r = 0; r < 3; r++) begin
      load_random();
      drive_capture();
    end
    drain();
    ready_rand = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
